fip_32_3b3_det_seq: RTL and testbench

Sequential 3x3 signed fixed-point determinant engine built around one shared 32-bit fixed-point multiplier instead of nine parallel ones. The unit sits between the ray/triangle setup stage and the downstream consumers of determinants. It uses valid/ready handshakes on both sides and schedules the nine multiplies over nine cycles. It reports a sticky overflow flag per result.

---
 rtl/fip_32_3b3_det_seq_if.sv | 25 ++
 rtl/fip_32_3b3_det_seq.sv | 180 ++++++++++++++++++
 tb/tb_fip_32_3b3_det_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fip_32_3b3_det_seq_if.sv
// Producer/consumer handshake bundle for the sequential 3x3 determinant engine.
interface fip_32_3b3_det_seq_if;
    localparam int unsigned DW = 32;

    logic [2:0][2:0][DW-1:0] i_array;
    logic                    i_valid;
    logic                    i_ready;
    logic [DW-1:0]           o_det;
    logic                    o_overflow;
    logic                    o_valid;
    logic                    o_ready;
    logic                    o_busy;

    // Producer and consumer side (the environment driving the engine).
    modport master (
        output i_array, i_valid, o_ready,
        input  i_ready, o_det, o_overflow, o_valid, o_busy
    );

    // Engine side.
    modport slave (
        input  i_array, i_valid, o_ready,
        output i_ready, o_det, o_overflow, o_valid, o_busy
    );
endinterface

// File: rtl/fip_32_3b3_det_seq.sv
// Sequential 3x3 signed fixed-point determinant using one shared multiplier,
// one multiply per cycle over nine steps, with a sticky overflow flag.
module fip_32_3b3_det_seq #(
    parameter int unsigned FRAC = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fip_32_3b3_det_seq_if.slave  bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned SW = 4;
    localparam logic [SW-1:0] LAST_STEP = SW'(8);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [SW-1:0]           step;
    logic [SW-1:0]           step_nxt;
    logic [2:0][2:0][DW-1:0] mat;
    logic [DW-1:0]           p_reg;
    logic [DW-1:0]           m_reg;
    logic [DW-1:0]           acc;
    logic [DW-1:0]           det_r;
    logic                    ovf;
    logic                    ovf_r;
    logic                    valid_r;
    logic                    ready_r;
    logic                    busy_r;
    logic                    accept;

    logic [DW-1:0]           mul_a;
    logic [DW-1:0]           mul_b;
    logic [PW-1:0]           prod;
    logic signed [PW-1:0]    shifted;
    logic [DW-1:0]           mul_res;
    logic                    mul_ovf;
    logic [DW-1:0]           as_x;
    logic [DW-1:0]           as_y;
    logic                    as_sub;
    logic [DW-1:0]           as_res;
    logic                    as_ovf;

    assign accept = (state == IDLE) && bus.i_valid;

    // Shared multiplier: low 64 bits of the sign-extended product equal the signed product.
    assign prod    = {{DW{mul_a[DW-1]}}, mul_a} * {{DW{mul_b[DW-1]}}, mul_b};
    assign shifted = $signed(prod) >>> FRAC;
    assign mul_res = shifted[DW-1:0];
    assign mul_ovf = ~((&shifted[PW-1:DW-1]) | ~(|shifted[PW-1:DW-1]));

    // Shared add/sub with signed-overflow detect (wrapped result kept).
    assign as_res = as_sub ? (as_x - as_y) : (as_x + as_y);
    assign as_ovf = as_sub ? ((as_x[DW-1] != as_y[DW-1]) && (as_res[DW-1] != as_x[DW-1]))
                           : ((as_x[DW-1] == as_y[DW-1]) && (as_res[DW-1] != as_x[DW-1]));

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            step  <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // Next-state and step sequencing.
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            IDLE: begin
                if (bus.i_valid) begin
                    state_nxt = BUSY;
                    step_nxt  = '0;
                end
            end
            BUSY: begin
                step_nxt = step + SW'(1);
                if (step == LAST_STEP) begin
                    state_nxt = DONE;
                    step_nxt  = '0;
                end
            end
            DONE: begin
                if (bus.o_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                step_nxt  = '0;
            end
        endcase
    end

    // Operand schedule: a..i are mat[0][0]..mat[2][2] read row by row.
    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        as_x   = p_reg;
        as_y   = mul_res;
        as_sub = 1'b1;
        case (step)
            SW'(0): begin mul_a = mat[1][1]; mul_b = mat[2][2]; end
            SW'(1): begin mul_a = mat[1][2]; mul_b = mat[2][1]; end
            SW'(2): begin mul_a = mat[0][0]; mul_b = m_reg;     end
            SW'(3): begin mul_a = mat[1][2]; mul_b = mat[2][0]; end
            SW'(4): begin mul_a = mat[1][0]; mul_b = mat[2][2]; end
            SW'(5): begin mul_a = mat[0][1]; mul_b = m_reg; as_x = acc; as_sub = 1'b0; end
            SW'(6): begin mul_a = mat[1][0]; mul_b = mat[2][1]; end
            SW'(7): begin mul_a = mat[1][1]; mul_b = mat[2][0]; end
            SW'(8): begin mul_a = mat[0][2]; mul_b = m_reg; as_x = acc; as_sub = 1'b0; end
            default: ;
        endcase
    end

    // Datapath: matrix capture, partial/minor/accumulator updates, result latch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mat   <= '0;
            p_reg <= '0;
            m_reg <= '0;
            acc   <= '0;
            det_r <= '0;
            ovf   <= 1'b0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            mat <= bus.i_array;
            ovf <= 1'b0;
        end else if (state == BUSY) begin
            case (step)
                SW'(0), SW'(3), SW'(6): begin
                    p_reg <= mul_res;
                    ovf   <= ovf | mul_ovf;
                end
                SW'(1), SW'(4), SW'(7): begin
                    m_reg <= as_res;
                    ovf   <= ovf | mul_ovf | as_ovf;
                end
                SW'(2): begin
                    acc <= mul_res;
                    ovf <= ovf | mul_ovf;
                end
                SW'(5): begin
                    acc <= as_res;
                    ovf <= ovf | mul_ovf | as_ovf;
                end
                SW'(8): begin
                    acc   <= as_res;
                    det_r <= as_res;
                    ovf   <= ovf | mul_ovf | as_ovf;
                    ovf_r <= ovf | mul_ovf | as_ovf;
                end
                default: ;
            endcase
        end
    end

    // Registered handshake/status flags derived from the upcoming state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            valid_r <= (state_nxt == DONE);
            ready_r <= (state_nxt == IDLE);
            busy_r  <= (state_nxt != IDLE);
        end
    end

    assign bus.o_det      = det_r;
    assign bus.o_overflow = ovf_r;
    assign bus.o_valid    = valid_r;
    assign bus.i_ready    = ready_r;
    assign bus.o_busy     = busy_r;
endmodule

// File: tb/tb_fip_32_3b3_det_seq.sv
// Randomized self-checking bench for the sequential 3x3 determinant engine.
module tb_fip_32_3b3_det_seq;
    localparam int unsigned FRAC = 16;
    localparam longint MAXV = 64'sh0000_0000_7FFF_FFFF;
    localparam longint MINV = -64'sh0000_0000_8000_0000;

    typedef logic [2:0][2:0][31:0] mat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fip_32_3b3_det_seq_if bus();

    fip_32_3b3_det_seq #(.FRAC(FRAC)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    logic m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: exact math in 64 bits, then range-check and wrap.
    function automatic logic [31:0] fx_mul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        p = p >>> FRAC;
        if (p > MAXV || p < MINV) m_ovf = 1'b1;
        return 32'(p);
    endfunction

    function automatic logic [31:0] fx_add(input logic [31:0] x, input logic [31:0] y);
        longint s;
        s = longint'($signed(x)) + longint'($signed(y));
        if (s > MAXV || s < MINV) m_ovf = 1'b1;
        return 32'(s);
    endfunction

    function automatic logic [31:0] fx_sub(input logic [31:0] x, input logic [31:0] y);
        longint s;
        s = longint'($signed(x)) - longint'($signed(y));
        if (s > MAXV || s < MINV) m_ovf = 1'b1;
        return 32'(s);
    endfunction

    // Cofactor expansion along row 0: a(ei-fh) + b(fg-di) + c(dh-eg).
    function automatic logic [31:0] model_det(input mat_t m);
        logic [31:0] c0, c1, c2, t;
        m_ovf = 1'b0;
        c0 = fx_sub(fx_mul(m[1][1], m[2][2]), fx_mul(m[1][2], m[2][1]));
        c1 = fx_sub(fx_mul(m[1][2], m[2][0]), fx_mul(m[1][0], m[2][2]));
        c2 = fx_sub(fx_mul(m[1][0], m[2][1]), fx_mul(m[1][1], m[2][0]));
        t  = fx_mul(m[0][0], c0);
        t  = fx_add(t, fx_mul(m[0][1], c1));
        t  = fx_add(t, fx_mul(m[0][2], c2));
        return t;
    endfunction

    function automatic mat_t diag(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        mat_t m;
        m = '0;
        m[0][0] = d0;
        m[1][1] = d1;
        m[2][2] = d2;
        return m;
    endfunction

    function automatic mat_t rand_mat(input bit wide);
        mat_t m;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m[r][c] = wide ? $urandom : (32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000);
        return m;
    endfunction

    // Offer a matrix, wait for the accept edge, then count edges until o_valid.
    task automatic start_mat(input mat_t mtx, output int waited, output int lat);
        bus.i_array = mtx;
        bus.i_valid = 1'b1;
        waited = 0;
        while (!bus.i_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_array = rand_mat(1'b1);
        lat = 0;
        while (!bus.o_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_res(input string tag, input int hold, input logic [31:0] det_exp);
        bus.o_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        if (hold > 0) check({tag, "_hold_det"}, bus.o_det, det_exp);
        bus.o_ready = 1'b1;
        @(posedge clk); #1;
        bus.o_ready = 1'b0;
        check({tag, "_valid_clr"}, 32'(bus.o_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.i_ready), 32'd1);
    endtask

    task automatic do_mat(input string tag, input mat_t mtx, input int hold);
        int          waited, lat;
        logic [31:0] exp_det;
        logic        exp_ovf;
        exp_det = model_det(mtx);
        exp_ovf = m_ovf;
        start_mat(mtx, waited, lat);
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_det"}, bus.o_det, exp_det);
        check({tag, "_ovf"}, 32'(bus.o_overflow), 32'(exp_ovf));
        check({tag, "_iready_lo"}, 32'(bus.i_ready), 32'd0);
        release_res(tag, hold, exp_det);
    endtask

    initial begin
        mat_t        m;
        logic [31:0] held_det;
        int          waited, lat;
        logic        stable, seen;

        rst = 1'b1;
        bus.i_array = '0;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_det",    bus.o_det,               32'd0);
        check("rst_ovf",    32'(bus.o_overflow),     32'd0);
        check("rst_valid",  32'(bus.o_valid),        32'd0);
        check("rst_busy",   32'(bus.o_busy),         32'd0);
        check("rst_iready", 32'(bus.i_ready),        32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed patterns with hand-derived results.
        m = diag(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        do_mat("ident", m, 0);
        check("ident_const", model_det(m), 32'h0001_0000);
        do_mat("diag234", diag(32'h0002_0000, 32'h0003_0000, 32'h0004_0000), 1);
        check("diag234_const", model_det(diag(32'h0002_0000, 32'h0003_0000, 32'h0004_0000)), 32'h0018_0000);
        m = '0;
        m[0][1] = 32'h0001_0000; m[1][0] = 32'h0001_0000; m[2][2] = 32'h0001_0000;
        do_mat("swap", m, 2);
        check("swap_const", model_det(m), 32'hFFFF_0000);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m[r][c] = 32'(3 * r + c + 1) << 16;
        do_mat("singular", m, 0);
        check("singular_const", model_det(m), 32'h0000_0000);
        do_mat("half", diag(32'h0000_8000, 32'h0000_8000, 32'h0000_8000), 0);
        check("half_const", model_det(diag(32'h0000_8000, 32'h0000_8000, 32'h0000_8000)), 32'h0000_2000);
        do_mat("big", diag(32'h0100_0000, 32'h0100_0000, 32'h0100_0000), 0);
        check("big_ovf_const", 32'(m_ovf), 32'd1);
        do_mat("after_big", diag(32'h0001_0000, 32'h0001_0000, 32'h0001_0000), 0);

        // Randomized matrices: mostly small magnitudes, some full-range for overflow.
        for (int k = 0; k < 40; k++) begin
            do_mat($sformatf("rnd%0d", k), rand_mat(($urandom_range(0, 3) == 0)),
                   int'($urandom_range(0, 3)));
        end

        // Backpressure: hold result 20 cycles while a new matrix is offered.
        do_mat("bp_first_pre", diag(32'h0002_0000, 32'h0003_0000, 32'h0004_0000), 0);
        m = diag(32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
        bus.i_array = m;
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        lat = 0;
        while (!bus.o_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd9);
        held_det = bus.o_det;
        check("bp_det", held_det, 32'h0018_0000);
        bus.i_array = diag(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        bus.i_valid = 1'b1;
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.o_det !== held_det || bus.o_valid !== 1'b1 || bus.i_ready !== 1'b0)
                stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_busy", 32'(bus.o_busy), 32'd1);
        bus.o_ready = 1'b1;
        @(posedge clk); #1;
        bus.o_ready = 1'b0;
        check("bp_idle_ready", 32'(bus.i_ready), 32'd1);
        check("bp_idle_valid", 32'(bus.o_valid), 32'd0);
        start_mat(diag(32'h0001_0000, 32'h0001_0000, 32'h0001_0000), waited, lat);
        check("bp_accept_wait", 32'(waited), 32'd0);
        check("bp_next_lat", 32'(lat), 32'd9);
        check("bp_next_det", bus.o_det, 32'h0001_0000);
        release_res("bp_next", 0, 32'h0001_0000);

        // Async reset partway through the schedule.
        bus.i_array = rand_mat(1'b0);
        bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid",  32'(bus.o_valid), 32'd0);
        check("arst_busy",   32'(bus.o_busy),  32'd0);
        check("arst_iready", 32'(bus.i_ready), 32'd1);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.o_valid) seen = 1'b1;
        end
        check("arst_no_result", 32'(seen), 32'd0);
        do_mat("arst_ident", diag(32'h0001_0000, 32'h0001_0000, 32'h0001_0000), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
